mem_stage: RTL and testbench

Pipeline MEM stage directly downstream of the EX stage. It holds the EX/MEM register, which captures the ALU result, forwarded store data, funct3 and writeback controls. It runs loads and stores against a req/ready data-memory port and handles byte/half alignment and sign extension. It produces the MEM/WB register, and it also drives the MEM- and WB-side forwarding sources (`rd_mem`, `regwrite_mem`, `wb_data_mem`, `rd_wb`, `regwrite_wb`, `write_data_wb`) that EX consumes.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage_align.sv | 69 ++++++
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: widths, funct3 encodings, FSM states.
package mem_stage_pkg;

    localparam int REG_DATA_WIDTH  = 32;
    localparam int DMEM_STRB_WIDTH = 4;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings (share size coding with loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready port shared by the MEM stage and the memory.
interface mem_stage_if #(
    parameter int XLEN = 32
);
    import mem_stage_pkg::*;

    logic                       dmem_req;
    logic                       dmem_we;
    logic [XLEN-1:0]            dmem_addr;
    logic [XLEN-1:0]            dmem_wdata;
    logic [DMEM_STRB_WIDTH-1:0] dmem_wstrb;
    logic                       dmem_ready;
    logic [XLEN-1:0]            dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_align.sv
// Byte/half/word lane handling: misalignment, store lane replication and
// strobes, and load lane extraction with sign/zero extension.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = REG_DATA_WIDTH
) (
    input  logic [2:0]                 funct3_i,
    input  logic [1:0]                 addr_i,
    input  logic [XLEN-1:0]            store_data_i,
    input  logic [XLEN-1:0]            rdata_i,
    output logic                       mis_o,
    output logic [XLEN-1:0]            wdata_o,
    output logic [DMEM_STRB_WIDTH-1:0] wstrb_o,
    output logic [XLEN-1:0]            load_data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the read word
    always_comb begin
        byte_s = rdata_i[{addr_i, 3'b000} +: 8];
        if (addr_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
    end

    // Size decode; undefined encodings fall through to word access
    always_comb begin
        mis_o       = 1'b0;
        wdata_o     = store_data_i;
        wstrb_o     = 4'b1111;
        load_data_o = rdata_i;
        case (funct3_i)
            F3_LB: begin  // also SB
                wdata_o     = {4{store_data_i[7:0]}};
                wstrb_o     = 4'b0001 << addr_i;
                load_data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            end
            F3_LBU: begin
                wdata_o     = {4{store_data_i[7:0]}};
                wstrb_o     = 4'b0001 << addr_i;
                load_data_o = {{(XLEN-8){1'b0}}, byte_s};
            end
            F3_LH: begin  // also SH
                mis_o       = addr_i[0];
                wdata_o     = {2{store_data_i[15:0]}};
                wstrb_o     = 4'b0011 << {addr_i[1], 1'b0};
                load_data_o = {{(XLEN-16){half_s[15]}}, half_s};
            end
            F3_LHU: begin
                mis_o       = addr_i[0];
                wdata_o     = {2{store_data_i[15:0]}};
                wstrb_o     = 4'b0011 << {addr_i[1], 1'b0};
                load_data_o = {{(XLEN-16){1'b0}}, half_s};
            end
            default: begin  // LW/SW and undefined encodings
                mis_o       = (addr_i != 2'b00);
                wdata_o     = store_data_i;
                wstrb_o     = 4'b1111;
                load_data_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake FSM with
// timeout, and MEM/WB register plus forwarding sources for EX.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = REG_DATA_WIDTH,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic            regwrite,
    input  logic            memread,
    input  logic            memwrite,
    output logic            stall,
    mem_stage_if.master     dmem,
    output logic [4:0]      rd_mem,
    output logic            regwrite_mem,
    output logic [XLEN-1:0] wb_data_mem,
    output logic [4:0]      rd_wb,
    output logic            regwrite_wb,
    output logic [XLEN-1:0] write_data_wb,
    output logic            exc_misaligned,
    output logic            exc_bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // EX/MEM register
    logic            em_valid_q, em_regwrite_q, em_memread_q, em_memwrite_q;
    logic [XLEN-1:0] em_alu_q, em_sd_q;
    logic [2:0]      em_funct3_q;
    logic [4:0]      em_rd_q;

    // FSM
    mem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            req_s, busy_s, retire_s, buserr_s, stall_s;

    // Lane logic
    logic                       mis_s, is_mem_s, go_s, mis_op_s;
    logic [XLEN-1:0]            wdata_s, load_data_s;
    logic [DMEM_STRB_WIDTH-1:0] wstrb_s;

    // MEM/WB register
    logic [4:0]      rd_wb_q;
    logic            regwrite_wb_q, exc_mis_q, exc_bus_q;
    logic [XLEN-1:0] write_data_wb_q;

    mem_align #(.XLEN(XLEN)) u_align (
        .funct3_i     (em_funct3_q),
        .addr_i       (em_alu_q[1:0]),
        .store_data_i (em_sd_q),
        .rdata_i      (dmem.dmem_rdata),
        .mis_o        (mis_s),
        .wdata_o      (wdata_s),
        .wstrb_o      (wstrb_s),
        .load_data_o  (load_data_s)
    );

    assign is_mem_s = em_valid_q & (em_memread_q | em_memwrite_q);
    assign mis_op_s = is_mem_s & mis_s;
    assign go_s     = is_mem_s & ~mis_s;

    // EX/MEM capture; frozen while the memory op is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            em_valid_q    <= 1'b0;
            em_alu_q      <= '0;
            em_sd_q       <= '0;
            em_funct3_q   <= 3'b000;
            em_rd_q       <= 5'd0;
            em_regwrite_q <= 1'b0;
            em_memread_q  <= 1'b0;
            em_memwrite_q <= 1'b0;
        end else if (!stall_s) begin
            em_valid_q    <= ex_valid;
            em_alu_q      <= alu_result;
            em_sd_q       <= store_data;
            em_funct3_q   <= funct3;
            em_rd_q       <= rd;
            em_regwrite_q <= regwrite;
            em_memread_q  <= memread;
            em_memwrite_q <= memwrite;
        end
    end

    // Handshake FSM state and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, request and retire decisions; timeout abandons the request
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_s    = 1'b0;
        busy_s   = 1'b0;
        retire_s = 1'b0;
        buserr_s = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                cnt_d = '0;
                if (go_s) begin
                    req_s  = 1'b1;
                    busy_s = 1'b1;
                    if (dmem.dmem_ready) begin
                        retire_s = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                busy_s = 1'b1;
                if (dmem.dmem_ready) begin
                    req_s    = 1'b1;
                    retire_s = 1'b1;
                    state_d  = MEM_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    retire_s = 1'b1;
                    buserr_s = 1'b1;
                    state_d  = MEM_IDLE;
                end else begin
                    req_s = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_s = busy_s & ~retire_s;

    // MEM/WB update on every non-stalled edge; exception flags are one-shot
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wb_q         <= 5'd0;
            regwrite_wb_q   <= 1'b0;
            write_data_wb_q <= '0;
            exc_mis_q       <= 1'b0;
            exc_bus_q       <= 1'b0;
        end else if (!stall_s) begin
            rd_wb_q         <= em_rd_q;
            regwrite_wb_q   <= em_valid_q & em_regwrite_q & ~mis_op_s & ~buserr_s;
            write_data_wb_q <= em_memread_q ? load_data_s : em_alu_q;
            exc_mis_q       <= mis_op_s;
            exc_bus_q       <= buserr_s;
        end else begin
            exc_mis_q       <= 1'b0;
            exc_bus_q       <= 1'b0;
        end
    end

    assign stall           = stall_s;
    assign dmem.dmem_req   = req_s;
    assign dmem.dmem_we    = req_s & em_memwrite_q;
    assign dmem.dmem_addr  = {em_alu_q[XLEN-1:2], 2'b00};
    assign dmem.dmem_wdata = wdata_s;
    assign dmem.dmem_wstrb = (req_s & em_memwrite_q) ? wstrb_s : {DMEM_STRB_WIDTH{1'b0}};

    assign rd_mem          = em_rd_q;
    assign regwrite_mem    = em_valid_q & em_regwrite_q;
    assign wb_data_mem     = em_alu_q;
    assign rd_wb           = rd_wb_q;
    assign regwrite_wb     = regwrite_wb_q;
    assign write_data_wb   = write_data_wb_q;
    assign exc_misaligned  = exc_mis_q;
    assign exc_bus         = exc_bus_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU passthrough, loads, stores, misalign,
// timeout and reset-in-WAIT, with hand-computed expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, regwrite, memread, memwrite;
    logic [31:0] alu_result, store_data;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        stall, regwrite_mem, regwrite_wb, exc_misaligned, exc_bus;
    logic [4:0]  rd_mem, rd_wb;
    logic [31:0] wb_data_mem, write_data_wb;

    int n_cmp = 0;
    int n_err = 0;

    // results of run_mem
    int          stall_n, req_n;
    logic [31:0] w0, a0;
    logic [3:0]  s0;
    logic        stable, req_last, done;

    mem_stage_if #(.XLEN(32)) dif ();

    mem_stage #(.XLEN(32), .TIMEOUT(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .funct3         (funct3),
        .rd             (rd),
        .regwrite       (regwrite),
        .memread        (memread),
        .memwrite       (memwrite),
        .stall          (stall),
        .dmem           (dif),
        .rd_mem         (rd_mem),
        .regwrite_mem   (regwrite_mem),
        .wb_data_mem    (wb_data_mem),
        .rd_wb          (rd_wb),
        .regwrite_wb    (regwrite_wb),
        .write_data_wb  (write_data_wb),
        .exc_misaligned (exc_misaligned),
        .exc_bus        (exc_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [2:0] f3, input logic [4:0] r,
                         input logic rw, input logic mr, input logic mw);
        ex_valid = v; alu_result = alu; store_data = sd; funct3 = f3;
        rd = r; regwrite = rw; memread = mr; memwrite = mw;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Play memory for the op held in EX/MEM: ready pulses in cycle ready_at
    // (never if negative). Returns after the retire edge.
    task automatic run_mem(input int ready_at);
        stall_n = 0; req_n = 0; stable = 1'b1; done = 1'b0; req_last = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            dif.dmem_ready = (c == ready_at);
            #1;
            if (c == 0) begin
                w0 = dif.dmem_wdata; s0 = dif.dmem_wstrb; a0 = dif.dmem_addr;
            end else if (dif.dmem_req &&
                         (dif.dmem_wdata != w0 || dif.dmem_wstrb != s0 || dif.dmem_addr != a0)) begin
                stable = 1'b0;
            end
            if (dif.dmem_req) req_n++;
            req_last = dif.dmem_req;
            if (stall) stall_n++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        dif.dmem_ready = 1'b0;
        chk("op_retired", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bubble();
        dif.dmem_ready = 1'b0;
        dif.dmem_rdata = 32'h0;

        // Reset state
        step(); step();
        chk("rst_stall",    {31'd0, stall},           32'd0);
        chk("rst_req",      {31'd0, dif.dmem_req},    32'd0);
        chk("rst_rd_wb",    {27'd0, rd_wb},           32'd0);
        chk("rst_rw_wb",    {31'd0, regwrite_wb},     32'd0);
        chk("rst_wd_wb",    write_data_wb,            32'd0);
        chk("rst_rw_mem",   {31'd0, regwrite_mem},    32'd0);
        chk("rst_exc",      {30'd0, exc_bus, exc_misaligned}, 32'd0);
        rst = 1'b0;

        // ALU passthrough
        drive(1'b1, 32'h1234, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 chk("alu_stall0", {31'd0, stall}, 32'd0);
        step();
        bubble();
        #1;
        chk("alu_wb_mem",  wb_data_mem,            32'h1234);
        chk("alu_rd_mem",  {27'd0, rd_mem},        32'd5);
        chk("alu_rw_mem",  {31'd0, regwrite_mem},  32'd1);
        chk("alu_stall1",  {31'd0, stall},         32'd0);
        step();
        chk("alu_wd_wb",   write_data_wb,          32'h1234);
        chk("alu_rw_wb",   {31'd0, regwrite_wb},   32'd1);
        chk("alu_rd_wb",   {27'd0, rd_wb},         32'd5);
        chk("alu_rw_mem0", {31'd0, regwrite_mem},  32'd0);

        // LB sign extension, zero-wait
        dif.dmem_rdata = 32'h80FF_FF7F;
        drive(1'b1, 32'h103, 32'h0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0);
        step(); bubble();
        run_mem(0);
        chk("lb_stall",  stall_n,                32'd0);
        chk("lb_req",    req_n,                  32'd1);
        chk("lb_addr",   a0,                     32'h100);
        chk("lb_wstrb",  {28'd0, s0},            32'd0);
        chk("lb_data",   write_data_wb,          32'hFFFF_FF80);
        chk("lb_rw",     {31'd0, regwrite_wb},   32'd1);
        chk("lb_rd",     {27'd0, rd_wb},         32'd7);

        // LBU same address
        drive(1'b1, 32'h103, 32'h0, 3'b100, 5'd8, 1'b1, 1'b1, 1'b0);
        step(); bubble();
        run_mem(0);
        chk("lbu_stall", stall_n,       32'd0);
        chk("lbu_data",  write_data_wb, 32'h0000_0080);

        // LH sign extension from upper half
        drive(1'b1, 32'h102, 32'h0, 3'b001, 5'd9, 1'b1, 1'b1, 1'b0);
        step(); bubble();
        run_mem(0);
        chk("lh_data",   write_data_wb, 32'hFFFF_80FF);

        // SH with three wait cycles
        drive(1'b1, 32'h202, 32'hAAAA_BEEF, 3'b001, 5'd0, 1'b0, 1'b0, 1'b1);
        step(); bubble();
        run_mem(3);
        chk("sh_stall",  stall_n,              32'd3);
        chk("sh_req",    req_n,                32'd4);
        chk("sh_wdata",  w0,                   32'hBEEF_BEEF);
        chk("sh_wstrb",  {28'd0, s0},          32'hC);
        chk("sh_addr",   a0,                   32'h200);
        chk("sh_stable", {31'd0, stable},      32'd1);
        chk("sh_rw",     {31'd0, regwrite_wb}, 32'd0);
        chk("sh_excbus", {31'd0, exc_bus},     32'd0);

        // SB one wait cycle
        drive(1'b1, 32'h501, 32'h1234_5678, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1);
        step(); bubble();
        run_mem(1);
        chk("sb_stall",  stall_n,     32'd1);
        chk("sb_wdata",  w0,          32'h7878_7878);
        chk("sb_wstrb",  {28'd0, s0}, 32'h2);

        // Misaligned LW: no request, ready while idle is ignored
        drive(1'b1, 32'h101, 32'h0, 3'b010, 5'd9, 1'b1, 1'b1, 1'b0);
        step(); bubble();
        run_mem(0);
        chk("mis_stall", stall_n,                  32'd0);
        chk("mis_req",   req_n,                    32'd0);
        chk("mis_exc",   {31'd0, exc_misaligned},  32'd1);
        chk("mis_rw",    {31'd0, regwrite_wb},     32'd0);
        step();
        chk("mis_pulse", {31'd0, exc_misaligned},  32'd0);

        // Timeout with a following ALU op
        drive(1'b1, 32'h300, 32'h0, 3'b010, 5'd10, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h55, 32'h0, 3'b000, 5'd11, 1'b1, 1'b0, 1'b0);
        run_mem(-1);
        chk("to_stall",   stall_n,               32'd16);
        chk("to_req",     req_n,                 32'd16);
        chk("to_reqdrop", {31'd0, req_last},     32'd0);
        chk("to_excbus",  {31'd0, exc_bus},      32'd1);
        chk("to_rw",      {31'd0, regwrite_wb},  32'd0);
        chk("to_next_em", wb_data_mem,           32'h55);
        bubble();
        step();
        chk("to_pulse",   {31'd0, exc_bus},      32'd0);
        chk("to_next_wd", write_data_wb,         32'h55);
        chk("to_next_rw", {31'd0, regwrite_wb},  32'd1);

        // Reset while waiting
        drive(1'b1, 32'h400, 32'h0, 3'b010, 5'd12, 1'b1, 1'b1, 1'b0);
        step(); bubble();
        #1;
        chk("rw_stall_idle", {31'd0, stall},        32'd1);
        step();
        chk("rw_stall_wait", {31'd0, stall},        32'd1);
        chk("rw_req_wait",   {31'd0, dif.dmem_req}, 32'd1);
        rst = 1'b1;
        step();
        chk("rw_req",   {31'd0, dif.dmem_req},  32'd0);
        chk("rw_stall", {31'd0, stall},         32'd0);
        chk("rw_addr",  dif.dmem_addr,          32'd0);
        chk("rw_wd_wb", write_data_wb,          32'd0);
        chk("rw_rw_wb", {31'd0, regwrite_wb},   32'd0);
        chk("rw_mem",   wb_data_mem,            32'd0);
        rst = 1'b0;
        dif.dmem_rdata = 32'h1122_3344;
        drive(1'b1, 32'h404, 32'h0, 3'b010, 5'd13, 1'b1, 1'b1, 1'b0);
        step(); bubble();
        run_mem(1);
        chk("post_stall", stall_n,              32'd1);
        chk("post_data",  write_data_wb,        32'h1122_3344);
        chk("post_rw",    {31'd0, regwrite_wb}, 32'd1);
        chk("post_rd",    {27'd0, rd_wb},       32'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
